// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: next-PC selector encodings and FSM state type shared by the pc_unit slice
package pc_unit_pkg;
  typedef enum logic [2:0] {
    NPC_PC4  = 3'd0,
    NPC_BEQ  = 3'd1,
    NPC_BNE  = 3'd2,
    NPC_BLT  = 3'd3,
    NPC_BGE  = 3'd4,
    NPC_JAL  = 3'd5,
    NPC_JALR = 3'd6,
    NPC_RSV  = 3'd7
  } npc_op_e;
  typedef enum logic {ST_RUN, ST_ERR} state_e;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control/ALU-side inputs and PC-side outputs of the next-PC stage.
// master drives npc_op/br_zero/br_sgn/imm/alu_c/fetch_ready and observes pc/pc4/npc/err/err_pc/retired;
// slave is the pc_unit view.
interface pc_unit_if #(parameter int CNT_W = 32);
  logic [2:0]       npc_op;
  logic             br_zero;
  logic             br_sgn;
  logic [31:0]      imm;
  logic [31:0]      alu_c;
  logic             fetch_ready;
  logic [31:0]      pc;
  logic [31:0]      pc4;
  logic [31:0]      npc;
  logic             err;
  logic [31:0]      err_pc;
  logic [CNT_W-1:0] retired;
  modport master (
    output npc_op, br_zero, br_sgn, imm, alu_c, fetch_ready,
    input  pc, pc4, npc, err, err_pc, retired
  );
  modport slave (
    input  npc_op, br_zero, br_sgn, imm, alu_c, fetch_ready,
    output pc, pc4, npc, err, err_pc, retired
  );
endinterface

// File: rtl/pc_unit_npc_sel.sv
// npc_sel: combinational branch resolution and next-PC mux.
// i_op/i_zero/i_sgn/i_pc/i_imm/i_alu_c in; o_npc (candidate), o_pc4 (pc+4), o_misalign (npc[1]) out.
module npc_sel
  import pc_unit_pkg::*;
(
  input  npc_op_e     i_op,
  input  logic        i_zero,
  input  logic        i_sgn,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_alu_c,
  output logic [31:0] o_npc,
  output logic [31:0] o_pc4,
  output logic        o_misalign
);
  logic w_taken;
  always_comb begin
    o_pc4   = i_pc + 32'd4;
    w_taken = (i_op == NPC_BEQ &&  i_zero) || (i_op == NPC_BNE && !i_zero) ||
              (i_op == NPC_BLT &&  i_sgn)  || (i_op == NPC_BGE && !i_sgn)  ||
              (i_op == NPC_JAL);
    // JALR clears bit 0 before the alignment check, so only bit 1 can fault
    o_npc      = i_op == NPC_JALR ? (i_alu_c & ~32'h1) : w_taken ? i_pc + i_imm : o_pc4;
    o_misalign = o_npc[1];
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural PC register, RUN/ERR state machine, sticky error PC and retired counter.
// cpu_clk/cpu_rst (async, active-high) plus pc_unit_if.slave bus carrying npc_op/flags/imm/alu_c/fetch_ready
// in and pc/pc4/npc/err/err_pc/retired out.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic       cpu_clk,
  input logic       cpu_rst,
  pc_unit_if.slave  bus
);
  state_e           r_state, w_state_nx;
  logic [31:0]      r_pc, r_err_pc, w_npc, w_pc4;
  logic [CNT_W-1:0] r_retired;
  logic             w_misalign, w_step;
  npc_sel u_sel (
    .i_op      (npc_op_e'(bus.npc_op)),
    .i_zero    (bus.br_zero),
    .i_sgn     (bus.br_sgn),
    .i_pc      (r_pc),
    .i_imm     (bus.imm),
    .i_alu_c   (bus.alu_c),
    .o_npc     (w_npc),
    .o_pc4     (w_pc4),
    .o_misalign(w_misalign)
  );
  assign w_step = r_state == ST_RUN && bus.fetch_ready;
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) r_state <= ST_RUN;
    else         r_state <= w_state_nx;
  always_comb w_state_nx = (w_step && w_misalign) ? ST_ERR : r_state;
  // a faulting update leaves pc and retired untouched and records the faulting PC
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_pc      <= RESET_PC;
      r_err_pc  <= '0;
      r_retired <= '0;
    end else if (w_step) begin
      if (w_misalign) r_err_pc <= r_pc;
      else begin
        r_pc      <= w_npc;
        r_retired <= r_retired + 1'b1;
      end
    end
  end
  always_comb begin
    bus.pc      = r_pc;
    bus.pc4     = w_pc4;
    bus.npc     = w_npc;
    bus.err     = r_state == ST_ERR;
    bus.err_pc  = r_err_pc;
    bus.retired = r_retired;
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit
module tb_pc_unit;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ret;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   n     = 0;
  exp_t q[$];
  pc_unit_if #(.CNT_W(32)) bus ();
  pc_unit #(.RESET_PC(32'h0), .CNT_W(32)) u_dut (
    .cpu_clk(clk),
    .cpu_rst(rst),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [2:0] op, input logic z, input logic s, input logic [31:0] imm,
                      input logic [31:0] alu, input logic fr, input logic [31:0] e_npc,
                      input logic [31:0] e_pc, input logic [31:0] e_ret, input logic e_err);
    exp_t e;
    n++;
    bus.npc_op = op; bus.br_zero = z; bus.br_sgn = s;
    bus.imm = imm; bus.alu_c = alu; bus.fetch_ready = fr;
    q.push_back('{e_pc, e_ret, e_err});
    #1 chk($sformatf("s%0d_npc", n), bus.npc, e_npc);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk($sformatf("s%0d_pc", n), bus.pc, e.pc);
    chk($sformatf("s%0d_retired", n), bus.retired, e.ret);
    chk($sformatf("s%0d_err", n), {31'b0, bus.err}, {31'b0, e.err});
  endtask
  initial begin
    bus.npc_op = 3'd0; bus.br_zero = 1'b0; bus.br_sgn = 1'b0;
    bus.imm = '0; bus.alu_c = '0; bus.fetch_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_retired", bus.retired, 32'h0);
    chk("rst_err", {31'b0, bus.err}, 32'h0);
    chk("rst_err_pc", bus.err_pc, 32'h0);
    chk("rst_pc4", bus.pc4, 32'h4);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release_pc", bus.pc, 32'h0);
    //    op    z     s     imm           alu           fr    npc           pc            ret  err
    step(3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h4,        32'h4,        1,   1'b0);
    step(3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h8,        32'h8,        2,   1'b0);
    step(3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'hC,        32'hC,        3,   1'b0);
    step(3'd6, 1'b0, 1'b0, 32'h0,        32'h101,      1'b1, 32'h100,      32'h100,      4,   1'b0);
    step(3'd1, 1'b1, 1'b0, 32'h20,       32'h0,        1'b1, 32'h120,      32'h120,      5,   1'b0);
    step(3'd1, 1'b0, 1'b0, 32'h20,       32'h0,        1'b1, 32'h124,      32'h124,      6,   1'b0);
    step(3'd2, 1'b0, 1'b0, 32'h20,       32'h0,        1'b1, 32'h144,      32'h144,      7,   1'b0);
    step(3'd2, 1'b1, 1'b0, 32'h20,       32'h0,        1'b1, 32'h148,      32'h148,      8,   1'b0);
    step(3'd6, 1'b0, 1'b0, 32'h0,        32'h200,      1'b1, 32'h200,      32'h200,      9,   1'b0);
    step(3'd3, 1'b0, 1'b1, 32'hFFFFFFF0, 32'h0,        1'b1, 32'h1F0,      32'h1F0,      10,  1'b0);
    step(3'd6, 1'b0, 1'b0, 32'h0,        32'h200,      1'b1, 32'h200,      32'h200,      11,  1'b0);
    step(3'd4, 1'b0, 1'b1, 32'hFFFFFFF0, 32'h0,        1'b1, 32'h204,      32'h204,      12,  1'b0);
    step(3'd4, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h0,        1'b1, 32'h1F4,      32'h1F4,      13,  1'b0);
    step(3'd3, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h0,        1'b1, 32'h1F8,      32'h1F8,      14,  1'b0);
    step(3'd7, 1'b1, 1'b1, 32'h40,       32'h0,        1'b1, 32'h1FC,      32'h1FC,      15,  1'b0);
    step(3'd5, 1'b0, 1'b0, 32'h100,      32'h0,        1'b1, 32'h2FC,      32'h2FC,      16,  1'b0);
    for (int i = 0; i < 4; i++)
      step(3'd5, 1'b0, 1'b0, 32'h40,     32'h0,        1'b0, 32'h33C,      32'h2FC,      16,  1'b0);
    step(3'd5, 1'b0, 1'b0, 32'h40,       32'h0,        1'b1, 32'h33C,      32'h33C,      17,  1'b0);
    step(3'd5, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h33C,      32'h33C,      18,  1'b0);
    step(3'd5, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h33C,      32'h33C,      19,  1'b0);
    step(3'd6, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 20,  1'b0);
    chk("wrap_pc4", bus.pc4, 32'h0);
    step(3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0,        32'h0,        21,  1'b0);
    step(3'd6, 1'b0, 1'b0, 32'h0,        32'h1235,     1'b1, 32'h1234,     32'h1234,     22,  1'b0);
    step(3'd6, 1'b0, 1'b0, 32'h0,        32'h1236,     1'b1, 32'h1236,     32'h1234,     22,  1'b1);
    chk("err_pc", bus.err_pc, 32'h1234);
    for (int i = 0; i < 3; i++)
      step(3'd0, 1'b0, 1'b0, 32'h0,      32'h0,        1'b1, 32'h1238,     32'h1234,     22,  1'b1);
    step(3'd6, 1'b0, 1'b0, 32'h0,        32'h400,      1'b1, 32'h400,      32'h1234,     22,  1'b1);
    chk("err_pc_hold", bus.err_pc, 32'h1234);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", bus.pc, 32'h0);
    chk("async_rst_err", {31'b0, bus.err}, 32'h0);
    chk("async_rst_retired", bus.retired, 32'h0);
    chk("async_rst_err_pc", bus.err_pc, 32'h0);
    @(negedge clk) rst = 1'b0;
    step(3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h4,        32'h4,        1,   1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Next-PC stage of the single-cycle RV32I core; sits directly downstream of the ALU.
- Consumes the ALU `zero`/`sgn` flags and the ALU result, resolves branches and jumps, and holds the architectural PC register that feeds instruction fetch.
- Provides a fetch-ready stall, a sticky misaligned-target error state, and a retired-instruction counter used by trace comparison.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- cpu_clk  input  1  core clock; all state updates on the rising edge.
- cpu_rst  input  1  asynchronous, active-high reset.
- npc_op  input  3  next-PC selector from the control unit; encodings defined in param.v.
- br_zero  input  1  ALU `zero` flag for the current instruction.
- br_sgn  input  1  ALU `sgn` flag (C[31]) for the current instruction.
- imm  input  32  sign-extended immediate (B/J offset).
- alu_c  input  32  ALU result; JALR target before LSB clear.
- fetch_ready  input  1  instruction memory has the current instruction; PC may advance.
- pc  output  32  current PC (registered).
- pc4  output  32  pc + 4, for JAL/JALR link write-back.
- npc  output  32  combinational next-PC candidate.
- err  output  1  sticky misaligned-target error.
- err_pc  output  32  PC of the instruction that raised err.
- retired  output  CNT_W  count of accepted PC updates.

Behaviour:
- Reset (asynchronous, any time, including while stalled or in ERR):
  - pc = RESET_PC, err = 0, err_pc = 0, retired = 0, state = RUN.
  - Release is synchronous to the next cpu_clk edge.
- npc_op encodings:
  - NPC_PC4 = 0: npc = pc + 4.
  - NPC_BEQ = 1: taken if br_zero.
  - NPC_BNE = 2: taken if !br_zero.
  - NPC_BLT = 3: taken if br_sgn.
  - NPC_BGE = 4: taken if !br_sgn.
  - NPC_JAL = 5: always taken, target pc + imm.
  - NPC_JALR = 6: npc = alu_c & ~32'h1.
  - Value 7 is reserved and behaves as NPC_PC4.
- Branch target is pc + imm, computed with 32-bit wrap-around and no overflow detection. A not-taken branch gives npc = pc + 4.
- BLT/BGE take the ALU SUB sign bit as the comparison result. Signed-overflow cases are out of scope for this core revision; the control unit issues SUB for all branches.
- pc4 = pc + 4 and wraps at 32'hFFFF_FFFC -> 0.
- Misalignment: the target is misaligned when npc[1] == 1 (after the JALR LSB clear).
- State RUN:
  - On a rising edge with fetch_ready = 1 and npc aligned: pc <= npc, retired <= retired + 1 (wraps at 2^CNT_W).
  - On a rising edge with fetch_ready = 1 and npc misaligned: pc holds, err <= 1, err_pc <= pc, retired unchanged, state -> ERR.
  - fetch_ready = 0: pc, retired and state hold, whatever npc_op is (stall).
- State ERR: pc, retired, err and err_pc hold indefinitely, ignoring all inputs. Only cpu_rst exits ERR.
- Latency: npc is combinational from the inputs in the same cycle. pc reflects npc one edge later.
- Self-loop (JAL with imm = 0) is legal: pc stays the same, but retired increments every accepted cycle.

Decomposition:
- param.v (shared macro file) gains NPC_PC4 through NPC_JALR, alongside the existing ALU op macros.
- One natural sub-module, `npc_sel`: purely combinational branch resolution and target mux (npc_op, flags, pc, imm, alu_c -> npc, misalign).
- pc_unit contains the PC register, the RUN/ERR state machine, err_pc, and the retired counter.

Test Plan:
- Reset then 3 cycles of NPC_PC4 with fetch_ready = 1 -> pc = 0x0, 0x4, 0x8, 0xC; retired = 3.
- pc = 0x100, NPC_BEQ, imm = 0x20, br_zero = 1 -> pc = 0x120. Repeat with br_zero = 0 -> pc = 0x124.
- pc = 0x200, NPC_BLT, imm = 32'hFFFF_FFF0, br_sgn = 1 -> pc = 0x1F0. Same setup with NPC_BGE -> pc = 0x204.
- NPC_JALR, alu_c = 0x0000_1235 -> pc = 0x1234. Then alu_c = 0x0000_1236 -> err = 1, err_pc = 0x1234, pc stays 0x1234, and retired does not increment on later edges.
- fetch_ready held 0 for 4 cycles with NPC_JAL active -> pc and retired unchanged. Raise fetch_ready -> a single update to pc + imm.
- Assert cpu_rst mid-cycle between edges while in ERR -> pc = RESET_PC and err = 0 immediately, without waiting for a clock edge.
